krnl_aurora_link_ctrl: RTL and testbench
========================================

Name: krnl_aurora_link_ctrl

Overview:
Bring-up and recovery sequencer for the Aurora 64B/66B core inside krnl_aurora. It drives the core's reset_pb and pma_init in the vendor-mandated order, then waits for channel_up with a timeout and retries on failure. It also detects link drops and re-initialises the link automatically. Sticky status and counters feed the control slave's status register so the host can observe link health.

Parameters:
PB_LEAD, 128, cycles reset_pb is asserted before pma_init rises
PMA_HOLD, 1024, cycles pma_init is held high
PB_LAG, 128, cycles reset_pb stays high after pma_init falls
UP_TIMEOUT, 1000000, cycles allowed for channel_up after reset_pb release
MAX_RETRY, 7, failed bring-up attempts before entering FAIL (1..15)

Ports:
ACLK  in  1  kernel clock; all logic is on the rising edge
ARESET  in  1  synchronous active-high reset
enable  in  1  level input; 1 = bring up and hold the link, 0 = park in reset
channel_up  in  1  Aurora channel_up, already synchronous to ACLK
lane_up  in  4  Aurora lane_up, already synchronous to ACLK
reset_pb  out  1  Aurora reset_pb
pma_init  out  1  Aurora pma_init
link_ready  out  1  1 while in LINKED
link_fail  out  1  1 while in FAIL
retry_cnt  out  4  failed attempts in the current bring-up cycle
drop_cnt  out  8  link drops since reset, saturating at 255
status  out  16  {drop_cnt[7:0], link_fail, link_ready, channel_up, lane_up[3:0], 1'b0}

Behaviour:
- One clock and one reset: ACLK, and a synchronous active-high reset ARESET.
- States: IDLE, PB_ASSERT, PMA, PB_HOLD, WAIT_UP, LINKED, FAIL.
- Outputs are registered and decoded from state.
  - reset_pb = 1 in IDLE, PB_ASSERT, PMA, PB_HOLD and FAIL.
  - pma_init = 1 in IDLE, PMA and FAIL.
- Reset values: state = IDLE, reset_pb = 1, pma_init = 1, link_ready = 0, link_fail = 0, retry_cnt = 0, drop_cnt = 0, dwell counter = 0.
- ARESET aborts any sequence in the same cycle it is sampled.
- Dwell counter:
  - Loaded with N-1 on entry to each timed state.
  - Decrements every cycle; the state exits when the counter is 0.
  - Each timed state therefore lasts exactly N cycles (PB_LEAD, PMA_HOLD, PB_LAG).
  - The counter width is clog2(UP_TIMEOUT).
- IDLE: if enable = 1, go to PB_ASSERT and clear retry_cnt.
- PB_ASSERT → PMA → PB_HOLD → WAIT_UP in fixed order, using the dwell times above.
- WAIT_UP:
  - channel_up = 1 → LINKED.
  - Dwell expires with channel_up = 0:
    - If retry_cnt + 1 == MAX_RETRY, increment retry_cnt and go to FAIL.
    - Otherwise increment retry_cnt and go to PB_ASSERT.
  - If channel_up rises on the same cycle the dwell expires, channel_up wins (→ LINKED).
- LINKED:
  - link_ready = 1 and retry_cnt is cleared.
  - channel_up = 0 → increment drop_cnt (saturating) and go to PB_ASSERT. link_ready falls on the next cycle.
- FAIL: link_fail = 1 and resets are held. Exit only via enable = 0 → IDLE; retry_cnt is cleared on that exit.
- enable = 0 in any state other than IDLE → IDLE next cycle, with both resets reasserted. A drop counted in the same cycle is still counted.
- Simultaneous drop and enable = 0 in LINKED: drop_cnt increments and the next state is IDLE.
- lane_up is status-only and does not affect transitions.
- status is combinational from registered values and live lane_up/channel_up.

Decomposition:
- Shared package aurora_pkg:
  - state encoding (3-bit localparams);
  - status bit-field offsets, which the control slave also uses to place status at offset 0x10.
- One natural sub-module: aurora_dwell_timer, a loadable down-counter with a zero flag, parameterised by width.
- FSM and counters stay in the top module.

Test Plan:
- PB_LEAD=4, PMA_HOLD=8, PB_LAG=4, UP_TIMEOUT=32.
  - Stimulus: enable=1 at cycle 10, channel_up=1 at cycle 40.
  - Expected: pma_init high through the PMA dwell and low exactly 8 cycles after it rose; reset_pb falls 4 cycles after pma_init falls; link_ready=1 one cycle after channel_up is sampled; retry_cnt = 0.
- channel_up held at 0 with MAX_RETRY=3 → three 32-cycle WAIT_UP windows, then FAIL; link_fail = 1, retry_cnt = 3, resets held. Dropping enable → IDLE, retry_cnt = 0.
- From LINKED, pulse channel_up low for 1 cycle → drop_cnt = 1 and the full reset sequence re-runs. Repeat 300 drops → drop_cnt stays at 255.
- enable dropped during PMA → IDLE next cycle with reset_pb = pma_init = 1. Re-enable → the sequence restarts from PB_ASSERT with a full PB_LEAD dwell.
- channel_up rises on the final WAIT_UP cycle → LINKED, retry_cnt is not incremented.
- ARESET asserted mid-WAIT_UP with drop_cnt = 5 → all outputs return to reset values on the next edge, including drop_cnt = 0.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared definitions for the Aurora link controller: FSM state encoding and the
// bit layout of the link status word read by the control slave.
package aurora_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_PB_ASSERT = 3'd1;
   localparam logic [2:0] ST_PMA       = 3'd2;
   localparam logic [2:0] ST_PB_HOLD   = 3'd3;
   localparam logic [2:0] ST_WAIT_UP   = 3'd4;
   localparam logic [2:0] ST_LINKED    = 3'd5;
   localparam logic [2:0] ST_FAIL      = 3'd6;

   typedef enum logic [2:0] {
      StIdle     = ST_IDLE,
      StPbAssert = ST_PB_ASSERT,
      StPma      = ST_PMA,
      StPbHold   = ST_PB_HOLD,
      StWaitUp   = ST_WAIT_UP,
      StLinked   = ST_LINKED,
      StFail     = ST_FAIL
   } link_state_e;

   // Status word layout; the control slave maps this word at offset 0x10.
   localparam int unsigned STAT_LANE_LSB  = 1;
   localparam int unsigned STAT_CHUP_BIT  = 5;
   localparam int unsigned STAT_READY_BIT = 6;
   localparam int unsigned STAT_FAIL_BIT  = 7;
   localparam int unsigned STAT_DROP_LSB  = 8;
   localparam logic [7:0]  STATUS_REG_OFFSET = 8'h10;

endpackage

// File: rtl/aurora_dwell_timer.sv
// Loadable down-counter that stops at zero; o_zero flags expiry of the
// current dwell.
module aurora_dwell_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != '0) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/krnl_aurora_link_ctrl.sv
// Aurora 64B/66B bring-up and recovery sequencer: orders reset_pb/pma_init,
// waits for channel_up with retries, and re-initialises on link drops.
module krnl_aurora_link_ctrl
   import aurora_pkg::*;
#(
   parameter int unsigned PB_LEAD    = 128,
   parameter int unsigned PMA_HOLD   = 1024,
   parameter int unsigned PB_LAG     = 128,
   parameter int unsigned UP_TIMEOUT = 1000000,
   parameter int unsigned MAX_RETRY  = 7
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        enable,
   input  logic        channel_up,
   input  logic [3:0]  lane_up,
   output logic        reset_pb,
   output logic        pma_init,
   output logic        link_ready,
   output logic        link_fail,
   output logic [3:0]  retry_cnt,
   output logic [7:0]  drop_cnt,
   output logic [15:0] status
);

   localparam int unsigned CW = (UP_TIMEOUT > 2) ? $clog2(UP_TIMEOUT) : 1;
   localparam logic [CW-1:0] LD_LEAD = CW'(PB_LEAD - 1);
   localparam logic [CW-1:0] LD_PMA  = CW'(PMA_HOLD - 1);
   localparam logic [CW-1:0] LD_LAG  = CW'(PB_LAG - 1);
   localparam logic [CW-1:0] LD_UP   = CW'(UP_TIMEOUT - 1);
   localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

   link_state_e   r_state;
   link_state_e   w_state_nxt;
   logic          r_reset_pb;
   logic          r_pma_init;
   logic          r_link_ready;
   logic          r_link_fail;
   logic [3:0]    r_retry_cnt;
   logic [3:0]    w_retry_nxt;
   logic [3:0]    w_retry_inc;
   logic [7:0]    r_drop_cnt;
   logic [7:0]    w_drop_nxt;
   logic          w_load;
   logic [CW-1:0] w_load_val;
   logic          w_dwell_zero;
   logic [15:0]   w_status;

   aurora_dwell_timer #(
      .WIDTH (CW)
   ) u_dwell (
      .i_clk   (ACLK),
      .i_rst   (ARESET),
      .i_load  (w_load),
      .i_value (w_load_val),
      .o_zero  (w_dwell_zero)
   );

   assign w_retry_inc = r_retry_cnt + 4'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_retry_nxt = r_retry_cnt;
      w_drop_nxt  = r_drop_cnt;
      w_load      = 1'b0;
      w_load_val  = '0;
      case (r_state)
         StIdle: begin
            if (enable) begin
               w_state_nxt = StPbAssert;
               w_load      = 1'b1;
               w_load_val  = LD_LEAD;
               w_retry_nxt = 4'd0;
            end
         end
         StPbAssert: begin
            if (w_dwell_zero) begin
               w_state_nxt = StPma;
               w_load      = 1'b1;
               w_load_val  = LD_PMA;
            end
         end
         StPma: begin
            if (w_dwell_zero) begin
               w_state_nxt = StPbHold;
               w_load      = 1'b1;
               w_load_val  = LD_LAG;
            end
         end
         StPbHold: begin
            if (w_dwell_zero) begin
               w_state_nxt = StWaitUp;
               w_load      = 1'b1;
               w_load_val  = LD_UP;
            end
         end
         StWaitUp: begin
            // channel_up takes priority over a timeout in the same cycle
            if (channel_up) begin
               w_state_nxt = StLinked;
               w_retry_nxt = 4'd0;
            end else if (w_dwell_zero) begin
               w_retry_nxt = w_retry_inc;
               if (w_retry_inc == RETRY_LIMIT) begin
                  w_state_nxt = StFail;
               end else begin
                  w_state_nxt = StPbAssert;
                  w_load      = 1'b1;
                  w_load_val  = LD_LEAD;
               end
            end
         end
         StLinked: begin
            w_retry_nxt = 4'd0;
            if (!channel_up) begin
               if (r_drop_cnt != 8'hff) begin
                  w_drop_nxt = r_drop_cnt + 8'd1;
               end
               w_state_nxt = StPbAssert;
               w_load      = 1'b1;
               w_load_val  = LD_LEAD;
            end
         end
         StFail: begin
            if (!enable) begin
               w_state_nxt = StIdle;
               w_retry_nxt = 4'd0;
            end
         end
         default: w_state_nxt = StIdle;
      endcase

      // Dropping enable parks the link; counter updates above still apply.
      if (!enable && (r_state != StIdle)) begin
         w_state_nxt = StIdle;
         w_load      = 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state      <= StIdle;
         r_reset_pb   <= 1'b1;
         r_pma_init   <= 1'b1;
         r_link_ready <= 1'b0;
         r_link_fail  <= 1'b0;
         r_retry_cnt  <= 4'd0;
         r_drop_cnt   <= 8'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_reset_pb   <= (w_state_nxt != StWaitUp) && (w_state_nxt != StLinked);
         r_pma_init   <= (w_state_nxt == StIdle) || (w_state_nxt == StPma) ||
                         (w_state_nxt == StFail);
         r_link_ready <= (w_state_nxt == StLinked);
         r_link_fail  <= (w_state_nxt == StFail);
         r_retry_cnt  <= w_retry_nxt;
         r_drop_cnt   <= w_drop_nxt;
      end
   end

   always_comb begin
      w_status                           = '0;
      w_status[STAT_LANE_LSB +: 4]       = lane_up;
      w_status[STAT_CHUP_BIT]            = channel_up;
      w_status[STAT_READY_BIT]           = r_link_ready;
      w_status[STAT_FAIL_BIT]            = r_link_fail;
      w_status[STAT_DROP_LSB +: 8]       = r_drop_cnt;
   end

   assign reset_pb   = r_reset_pb;
   assign pma_init   = r_pma_init;
   assign link_ready = r_link_ready;
   assign link_fail  = r_link_fail;
   assign retry_cnt  = r_retry_cnt;
   assign drop_cnt   = r_drop_cnt;
   assign status     = w_status;

endmodule

// File: tb/tb_krnl_aurora_link_ctrl.sv
// Directed bench for krnl_aurora_link_ctrl with short dwell times: a phase
// table for bring-up/drop/re-enable, then hand sequences for retry, saturation
// and reset corners.
module tb_krnl_aurora_link_ctrl;

   logic        ACLK;
   logic        ARESET;
   logic        enable;
   logic        channel_up;
   logic [3:0]  lane_up;
   logic        reset_pb;
   logic        pma_init;
   logic        link_ready;
   logic        link_fail;
   logic [3:0]  retry_cnt;
   logic [7:0]  drop_cnt;
   logic [15:0] status;

   int n_tests = 0;
   int n_fail  = 0;

   krnl_aurora_link_ctrl #(
      .PB_LEAD    (4),
      .PMA_HOLD   (8),
      .PB_LAG     (4),
      .UP_TIMEOUT (32),
      .MAX_RETRY  (3)
   ) dut (
      .ACLK       (ACLK),
      .ARESET     (ARESET),
      .enable     (enable),
      .channel_up (channel_up),
      .lane_up    (lane_up),
      .reset_pb   (reset_pb),
      .pma_init   (pma_init),
      .link_ready (link_ready),
      .link_fail  (link_fail),
      .retry_cnt  (retry_cnt),
      .drop_cnt   (drop_cnt),
      .status     (status)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   typedef struct {
      string      name;
      logic       en;
      logic       cup;
      logic [3:0] lane;
      int         cycles;
      logic       pb;
      logic       pma;
      logic       rdy;
      logic       fail;
      logic [3:0] retry;
      logic [7:0] drop;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(string n, logic en, logic cup, logic [3:0] lane, int cyc,
                               logic pb, logic pma, logic rdy, logic fail,
                               logic [3:0] retry, logic [7:0] drop);
      vec_t v;
      v.name = n; v.en = en; v.cup = cup; v.lane = lane; v.cycles = cyc;
      v.pb = pb; v.pma = pma; v.rdy = rdy; v.fail = fail; v.retry = retry; v.drop = drop;
      return v;
   endfunction

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge ACLK);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Full observable output state vs. expectation, status derived from the fields.
   task automatic check_all(input string name, input logic pb, input logic pma, input logic rdy,
                            input logic fail, input logic [3:0] retry, input logic [7:0] drop);
      logic [15:0] exp_status;
      exp_status = {drop, fail, rdy, channel_up, lane_up, 1'b0};
      check(name, {reset_pb, pma_init, link_ready, link_fail, retry_cnt, drop_cnt, status},
            {pb, pma, rdy, fail, retry, drop, exp_status});
   endtask

   task automatic do_reset();
      ARESET = 1'b1; enable = 1'b0; channel_up = 1'b0; lane_up = 4'h0;
      step(3);
      ARESET = 1'b0;
   endtask

   task automatic wait_pb_low(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (reset_pb == 1'b0) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
      check({name, "_wait_pb_low"}, 64'(ok), 64'd1);
   endtask

   task automatic wait_ready(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (link_ready == 1'b1) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
      check({name, "_wait_ready"}, 64'(ok), 64'd1);
   endtask

   initial begin
      int n;

      vecs[0]  = mk("idle_after_reset", 0, 0, 4'h0, 3, 1, 1, 0, 0, 0, 0);
      vecs[1]  = mk("pb_assert_entry",  1, 0, 4'h0, 1, 1, 0, 0, 0, 0, 0);
      vecs[2]  = mk("pb_assert_last",   1, 0, 4'h0, 3, 1, 0, 0, 0, 0, 0);
      vecs[3]  = mk("pma_rise",         1, 0, 4'h3, 1, 1, 1, 0, 0, 0, 0);
      vecs[4]  = mk("pma_last",         1, 0, 4'h3, 7, 1, 1, 0, 0, 0, 0);
      vecs[5]  = mk("pma_fall",         1, 0, 4'h3, 1, 1, 0, 0, 0, 0, 0);
      vecs[6]  = mk("pb_hold_last",     1, 0, 4'h3, 3, 1, 0, 0, 0, 0, 0);
      vecs[7]  = mk("pb_release",       1, 0, 4'h3, 1, 0, 0, 0, 0, 0, 0);
      vecs[8]  = mk("wait_up_mid",      1, 0, 4'ha, 10, 0, 0, 0, 0, 0, 0);
      vecs[9]  = mk("linked",           1, 1, 4'hf, 1, 0, 0, 1, 0, 0, 0);
      vecs[10] = mk("linked_hold",      1, 1, 4'hf, 5, 0, 0, 1, 0, 0, 0);
      vecs[11] = mk("drop_detect",      1, 0, 4'hf, 1, 1, 0, 0, 0, 0, 1);
      vecs[12] = mk("drop_rerun_pma",   1, 0, 4'h5, 4, 1, 1, 0, 0, 0, 1);
      vecs[13] = mk("disable_in_pma",   0, 0, 4'h5, 1, 1, 1, 0, 0, 0, 1);
      vecs[14] = mk("reenable_lead",    1, 0, 4'h0, 4, 1, 0, 0, 0, 0, 1);
      vecs[15] = mk("reenable_pma",     1, 0, 4'h0, 1, 1, 1, 0, 0, 0, 1);

      do_reset();
      for (int i = 0; i < 16; i++) begin
         enable = vecs[i].en; channel_up = vecs[i].cup; lane_up = vecs[i].lane;
         step(vecs[i].cycles);
         check_all(vecs[i].name, vecs[i].pb, vecs[i].pma, vecs[i].rdy, vecs[i].fail,
                   vecs[i].retry, vecs[i].drop);
      end

      // Retries exhaust into FAIL: three 32-cycle WAIT_UP windows.
      do_reset();
      enable = 1'b1;
      for (int w = 0; w < 3; w++) begin
         wait_pb_low($sformatf("retry_w%0d", w));
         n = 0;
         while (reset_pb == 1'b0 && n < 100) begin
            n++;
            step(1);
         end
         check($sformatf("retry_window_len_w%0d", w), 64'(n), 64'd32);
         if (w < 2) check_all($sformatf("retry_restart_w%0d", w), 1, 0, 0, 0, 4'(w + 1), 0);
         else       check_all("fail_entry", 1, 1, 0, 1, 4'd3, 0);
      end
      step(5);
      check_all("fail_held", 1, 1, 0, 1, 4'd3, 0);
      enable = 1'b0;
      step(1);
      check_all("fail_exit_idle", 1, 1, 0, 0, 4'd0, 0);

      // channel_up arriving on the final WAIT_UP cycle wins over the timeout.
      do_reset();
      enable = 1'b1;
      wait_pb_low("last_cycle");
      step(31);
      check_all("wait_up_final_cycle", 0, 0, 0, 0, 4'd0, 0);
      channel_up = 1'b1;
      step(1);
      check_all("up_on_last_cycle", 0, 0, 1, 0, 4'd0, 0);

      // Drop counter saturation.
      do_reset();
      enable = 1'b1; channel_up = 1'b1;
      wait_ready("sat_initial");
      for (int d = 1; d <= 300; d++) begin
         channel_up = 1'b0;
         step(1);
         if (d == 1)   check_all("first_drop", 1, 0, 0, 0, 4'd0, 8'd1);
         if (d == 254) check("drop_254", 64'(drop_cnt), 64'd254);
         if (d == 255) check("drop_255", 64'(drop_cnt), 64'd255);
         channel_up = 1'b1;
         wait_ready($sformatf("sat_d%0d", d));
      end
      check("drop_saturated", 64'(drop_cnt), 64'd255);

      // ARESET in WAIT_UP with drop_cnt = 5 returns everything to reset values.
      do_reset();
      enable = 1'b1; channel_up = 1'b1;
      wait_ready("areset_initial");
      for (int d = 0; d < 5; d++) begin
         channel_up = 1'b0;
         step(1);
         if (d < 4) begin
            channel_up = 1'b1;
            wait_ready($sformatf("areset_d%0d", d));
         end
      end
      wait_pb_low("areset_wait_up");
      check_all("areset_pre", 0, 0, 0, 0, 4'd0, 8'd5);
      ARESET = 1'b1;
      step(1);
      check_all("areset_applied", 1, 1, 0, 0, 4'd0, 8'd0);
      ARESET = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
